// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Passive checker for a two-road traffic-light controller. It runs on the
// controller's clock and only observes the 6-bit lamp vector. It does not
// drive the lamps.
//
// Functions:
//   - decodes the lamp vector into the phase 0..5 of the light cycle
//   - measures how long each phase lasts
//   - flags illegal lamp codes, out-of-order transitions and phase lengths
//     outside [DUR_MIN, max]. max is DUR_MAX_LONG for phase 3 and DUR_MAX
//     for every other phase.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   light[5:0]   lamps: [5] A grn, [4] A yel, [3] A red,
//                       [2] B grn, [1] B yel, [0] B red
//   phase[2:0]   decoded phase; meaningful only while phase_valid=1
//   phase_valid  monitor is locked to the sequence
//   fault        sticky, set by the first detected fault
//   fault_code   cause of the first fault:
//                  01 illegal code, 10 bad transition, 11 duration
//   last_dur     length in cycles of the most recently completed phase
//   cycle_count  number of completed 5->0 wraps (modulo 2^16)
//   cycle_done   one-cycle pulse on each 5->0 wrap
//
// All outputs are registered. A code change seen at edge k is reflected
// after edge k.

module traffic_light_monitor #(
  parameter int unsigned DUR_MIN      = 100000000,
  parameter int unsigned DUR_MAX      = 100000001,
  parameter int unsigned DUR_MAX_LONG = 200000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  light,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] last_dur,
  output logic [15:0] cycle_count,
  output logic        cycle_done
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } st_e;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_CODE = 2'b01;
  localparam logic [1:0] F_SEQ  = 2'b10;
  localparam logic [1:0] F_DUR  = 2'b11;

  localparam logic [31:0] MIN_W  = 32'(DUR_MIN);
  localparam logic [31:0] MAX_W  = 32'(DUR_MAX);
  localparam logic [31:0] MAXL_W = 32'(DUR_MAX_LONG);

  st_e         st_q, st_d;
  logic [5:0]  light_q;
  logic [31:0] dur_cnt;
  logic        partial_q, partial_d;
  logic [2:0]  phase_d;
  logic [1:0]  flt_d;
  logic        cyc_d;

  logic        chg;
  logic        code_ok, code_amb;
  logic [2:0]  code_ph;
  logic [2:0]  succ;
  logic [31:0] cur_max;
  logic        is_succ;
  logic        dur_bad;

  // ---------------------------------------------------------------------
  // Lamp decode. 001001 (A red, B red) appears both as phase 2 and as
  // phase 5. It is reported as ambiguous and resolved from sequence
  // context below.
  // ---------------------------------------------------------------------
  always_comb begin
    code_ok  = 1'b1;
    code_amb = 1'b0;
    code_ph  = 3'd0;
    case (light)
      6'b001100: code_ph  = 3'd0;
      6'b001010: code_ph  = 3'd1;
      6'b001001: code_amb = 1'b1;
      6'b100001: code_ph  = 3'd3;
      6'b010001: code_ph  = 3'd4;
      default:   code_ok  = 1'b0;
    endcase
  end

  assign chg     = (light != light_q);
  assign succ    = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  assign cur_max = (phase == 3'd3) ? MAXL_W : MAX_W;

  // The ambiguous code is a legal successor only when phase 2 or phase 5
  // is due next.
  assign is_succ = code_amb ? ((succ == 3'd2) || (succ == 3'd5))
                            : (code_ph == succ);

  // dur_cnt holds the full length of the departing phase at the change edge.
  assign dur_bad = (dur_cnt < MIN_W) || (dur_cnt > cur_max);

  // ---------------------------------------------------------------------
  // FSM: next state, next phase and the fault raised on this edge.
  // ---------------------------------------------------------------------
  always_comb begin
    st_d      = st_q;
    phase_d   = phase;
    partial_d = partial_q;
    flt_d     = F_NONE;
    cyc_d     = 1'b0;
    case (st_q)
      SYNC: begin
        // The ambiguous code and illegal codes give no sequence position,
        // so the monitor waits quietly for an unambiguous code. The first
        // phase is entered mid-way, so its length means nothing.
        if (chg && code_ok && !code_amb) begin
          st_d      = TRACK;
          phase_d   = code_ph;
          partial_d = 1'b1;
        end
      end
      TRACK: begin
        if (chg) begin
          if (!code_ok) begin
            flt_d = F_CODE;
            st_d  = SYNC;
          end else if (!is_succ) begin
            flt_d = F_SEQ;
            st_d  = SYNC;
          end else begin
            phase_d   = succ;
            partial_d = 1'b0;
            cyc_d     = (phase == 3'd5);
          end
          // The duration check of the departing phase has the lowest
          // priority on this edge.
          if (flt_d == F_NONE && !partial_q && dur_bad)
            flt_d = F_DUR;
        end else if (dur_cnt == cur_max) begin
          // Timeout fires on the edge where the count would pass max.
          // It fires once per phase and also covers the partial phase.
          flt_d = F_DUR;
        end
      end
      default: st_d = SYNC;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= SYNC;
      phase       <= 3'd0;
      partial_q   <= 1'b0;
      phase_valid <= 1'b0;
    end else begin
      st_q        <= st_d;
      phase       <= phase_d;
      partial_q   <= partial_d;
      phase_valid <= (st_d == TRACK);
    end
  end

  // ---------------------------------------------------------------------
  // Duration counter, cycle counter and sticky fault
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      light_q     <= 6'd0;
      dur_cnt     <= 32'd0;
      last_dur    <= 32'd0;
      cycle_count <= 16'd0;
      cycle_done  <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= F_NONE;
    end else begin
      light_q <= light;
      if (chg) begin
        dur_cnt  <= 32'd1;
        last_dur <= dur_cnt;
      end else if (dur_cnt != 32'hFFFF_FFFF) begin
        dur_cnt <= dur_cnt + 32'd1;
      end
      cycle_done <= cyc_d;
      if (cyc_d)
        cycle_count <= cycle_count + 16'd1;
      // Only the first fault is recorded. Later faults still steer the
      // FSM, but they do not overwrite the recorded cause.
      if (!fault && flt_d != F_NONE) begin
        fault      <= 1'b1;
        fault_code <= flt_d;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor.
// Stimulus is a stream of lamp segments (code, hold length). A segment-level
// reference model predicts every output after every clock edge.
module tb_traffic_light_monitor;

  localparam int MIN  = 3;
  localparam int MAX  = 5;
  localparam int MAXL = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  light = 6'd0;
  logic [2:0]  phase;
  logic        phase_valid, fault, cycle_done;
  logic [1:0]  fault_code;
  logic [31:0] last_dur;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  traffic_light_monitor #(
    .DUR_MIN(MIN), .DUR_MAX(MAX), .DUR_MAX_LONG(MAXL)
  ) dut (
    .clk(clk), .rst(rst), .light(light),
    .phase(phase), .phase_valid(phase_valid),
    .fault(fault), .fault_code(fault_code),
    .last_dur(last_dur), .cycle_count(cycle_count),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  logic [5:0] pcode [0:5];

  // reference model state
  int         m_lock, m_cur, m_part, m_flt, m_fc, m_last, m_cc, m_cd;
  int         prev_len;
  logic [5:0] prev_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // -1 illegal, 9 ambiguous (phase 2 or 5), otherwise the phase number
  function automatic int dec(input logic [5:0] c);
    case (c)
      6'b001100: return 0;
      6'b001010: return 1;
      6'b001001: return 9;
      6'b100001: return 3;
      6'b010001: return 4;
      default:   return -1;
    endcase
  endfunction

  function automatic int maxof(input int p);
    return (p == 3) ? MAXL : MAX;
  endfunction

  task automatic raise(input int f);
    if (f != 0 && m_flt == 0) begin
      m_flt = 1;
      m_fc  = f;
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_cur = 0; m_part = 0; m_flt = 0; m_fc = 0;
    m_last = 0; m_cc = 0; m_cd = 0; prev_len = 0; prev_code = 6'd0;
  endtask

  // Model the j-th edge (1-based) of a segment holding code c.
  task automatic model_edge(input logic [5:0] c, input int j);
    int d, nxt, f;
    bit ok;
    m_cd = 0;
    f    = 0;
    if (j == 1) begin
      d      = dec(c);
      m_last = prev_len;
      if (m_lock == 0) begin
        if (d >= 0 && d != 9) begin
          m_lock = 1; m_cur = d; m_part = 1;
        end
      end else begin
        nxt = (m_cur + 1) % 6;
        ok  = (d == 9) ? (nxt == 2 || nxt == 5) : (d == nxt);
        if (d < 0)    f = 1;
        else if (!ok) f = 2;
        else if (m_part == 0 && (prev_len < MIN || prev_len > maxof(m_cur))) f = 3;
        if (d < 0 || !ok) m_lock = 0;
        else begin
          if (m_cur == 5) begin
            m_cc++;
            m_cd = 1;
          end
          m_cur  = nxt;
          m_part = 0;
        end
      end
    end else if (m_lock != 0 && j == maxof(m_cur) + 1) begin
      f = 3;
    end
    raise(f);
  endtask

  task automatic chk_all();
    chk("valid", phase_valid, m_lock);
    if (m_lock != 0) chk("phase", phase, m_cur);
    chk("fault", fault, m_flt);
    chk("fault_code", fault_code, m_fc);
    chk("last_dur", last_dur, m_last);
    chk("cycle_count", cycle_count, m_cc & 32'hFFFF);
    chk("cycle_done", cycle_done, m_cd);
  endtask

  // Call just after a negedge. The task returns just after a negedge.
  task automatic seg(input logic [5:0] c, input int len);
    for (int j = 1; j <= len; j++) begin
      light = c;
      @(posedge clk);
      #1;
      model_edge(c, j);
      chk_all();
      @(negedge clk);
    end
    prev_len  = len;
    prev_code = c;
  endtask

  task automatic chk_rst_vals(input string pfx);
    chk({pfx, "_phase"}, phase, 0);
    chk({pfx, "_valid"}, phase_valid, 0);
    chk({pfx, "_fault"}, fault, 0);
    chk({pfx, "_fcode"}, fault_code, 0);
    chk({pfx, "_last"}, last_dur, 0);
    chk({pfx, "_cc"}, cycle_count, 0);
    chk({pfx, "_cd"}, cycle_done, 0);
  endtask

  // Pulse reset between edges and check the outputs before the next edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 chk_rst_vals("rst");
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [5:0] rand_illegal();
    logic [5:0] c;
    for (int k = 0; k < 100; k++) begin
      c = 6'($urandom_range(1, 63));
      if (dec(c) < 0) return c;
    end
    return 6'b111111;
  endfunction

  initial begin
    logic [5:0] c;
    int len, r, n, k;
    pcode[0] = 6'b001100; pcode[1] = 6'b001010; pcode[2] = 6'b001001;
    pcode[3] = 6'b100001; pcode[4] = 6'b010001; pcode[5] = 6'b001001;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_vals("init");
    rst = 1'b0;

    // legal loop, twice around
    for (int i = 0; i < 13; i++) seg(pcode[i % 6], 4);
    chk("loop_cc", cycle_count, 2);
    chk("loop_fault", fault, 0);

    // sync with the ambiguous code present at reset release
    do_reset();
    seg(6'b001001, 6);
    seg(6'b100001, 4);
    chk("amb_phase", phase, 3);
    chk("amb_fault", fault, 0);

    // illegal code from phase 1, then relock
    do_reset();
    seg(pcode[0], 4); seg(pcode[1], 4); seg(6'b111000, 2);
    chk("ill_fcode", fault_code, 1);
    for (int i = 0; i < 6; i++) seg(pcode[i], 4);
    chk("ill_keep", fault_code, 1);

    // skipped phase
    do_reset();
    seg(pcode[0], 4); seg(pcode[3], 4);
    chk("skip_fcode", fault_code, 2);

    // short phase
    do_reset();
    seg(pcode[0], 4); seg(pcode[1], 2); seg(pcode[2], 4);
    chk("win_fcode", fault_code, 3);

    // long green: 11 cycles times out, 10 does not
    do_reset();
    for (int i = 0; i < 3; i++) seg(pcode[i], 4);
    seg(pcode[3], 11);
    chk("to11_fcode", fault_code, 3);
    do_reset();
    for (int i = 0; i < 3; i++) seg(pcode[i], 4);
    seg(pcode[3], 10); seg(pcode[4], 4);
    chk("to10_fault", fault, 0);

    // reset in the middle of phase 4
    do_reset();
    for (int i = 0; i < 4; i++) seg(pcode[i], 4);
    seg(pcode[4], 2);
    do_reset();
    seg(pcode[4], 3);

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      if ((s % 20) == 19) do_reset();
      n = 0;
      do begin
        r = $urandom_range(99);
        if (r < 70)      c = (m_lock != 0) ? pcode[(m_cur + 1) % 6] : pcode[$urandom_range(5)];
        else if (r < 85) c = pcode[$urandom_range(5)];
        else             c = rand_illegal();
        n++;
      end while (c == prev_code && n < 20);
      if (c == prev_code) c = (prev_code == 6'b111111) ? 6'b110000 : 6'b111111;
      len = ($urandom_range(99) < 70) ? $urandom_range(MIN, MAX) : $urandom_range(1, 12);
      if (len >= 2 && $urandom_range(99) < 5) begin
        k = $urandom_range(1, len - 1);
        seg(c, k);
        do_reset();
        seg(c, len - k);
      end else begin
        seg(c, len);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that watches the 6-bit lamp vector driven by the traffic-light controller. It decodes the current phase and measures how long each phase lasts. It flags illegal lamp codes, out-of-order phase transitions and phase durations outside limits. It sits beside the controller on the same clock and drives status LEDs or a debug port; it never drives the lamps.

## Interface
- DUR_MIN, 100000000: minimum legal phase length in clock cycles, all phases.
- DUR_MAX, 100000001: maximum legal phase length, phases 0-2 and 4-5.
- DUR_MAX_LONG, 200000001: maximum legal phase length for phase 3 (A green, extended by the long-green switch).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- light  in  6  lamp vector: [5] A green, [4] A yellow, [3] A red, [2] B green, [1] B yellow, [0] B red.
- phase  out  3  decoded phase 0-5; meaningful only when phase_valid=1.
- phase_valid  out  1  monitor is locked to the sequence (TRACK state).
- fault  out  1  sticky; set on first detected fault.
- fault_code  out  2  first fault cause: 01 illegal code, 10 illegal transition, 11 duration out of range; 00 = none.
- last_dur  out  32  length in cycles of the most recently completed phase.
- cycle_count  out  16  completed full cycles (5->0 transitions); wraps at 16'hFFFF->0.
- cycle_done  out  1  one-cycle pulse on each 5->0 transition.

## Operation
- Legal codes and phases: 001100=0, 001010=1, 001001=2 or 5, 100001=3, 010001=4. All other codes are illegal.
- Ambiguous 001001: resolves to 2 after phase 1 and to 5 after phase 4.
- Successor rule: p -> (p+1) mod 6 only.
- Internal regs:
  - light_q: previous sample, reset 000000.
  - dur_cnt: 32-bit, reset 0, saturates at 32'hFFFFFFFF.
- Change event: light != light_q at a clock edge. On every edge light_q <= light.
- dur_cnt on a change event: loads 1 and last_dur <= dur_cnt.
- dur_cnt otherwise: increments, saturating.
- FSM SYNC (reset state), phase_valid=0:
  - Illegal codes and 001001 are ignored; no faults are raised.
  - A change event to an unambiguous legal code -> TRACK, with phase set to that code.
  - The first phase after entering TRACK is partial and is not duration-checked.
- FSM TRACK, phase_valid=1, on a change event:
  - New code illegal -> fault 01, go to SYNC.
  - New code legal but not the successor -> fault 10, go to SYNC.
  - Otherwise phase <= successor.
  - Departing phase (if not partial) with dur_cnt < DUR_MIN or > its max -> fault 11; stay in TRACK.
  - Transition 5->0: cycle_done=1 for one cycle and cycle_count increments.
- TRACK timeout: while stable, dur_cnt reaching max+1 (max = DUR_MAX_LONG for phase 3, DUR_MAX otherwise) -> fault 11, stay in TRACK. This check applies to partial phases too.
- Fault priority on the same edge: 01 > 10 > 11.
- fault and fault_code latch the first fault only. Later faults still drive the FSM but do not overwrite fault_code.
- Reset mid-operation: all state returns to its reset value immediately and asynchronously. The monitor then re-locks via SYNC.

## Timing
- Reset values: phase=0, phase_valid=0, fault=0, fault_code=00, last_dur=0, cycle_count=0, cycle_done=0, FSM=SYNC.
- All outputs are registered.
- A new code present on light before edge k is reflected in phase, last_dur, fault and cycle_done after edge k (1-cycle latency).
- A code held across exactly N edges yields last_dur=N at its departure.
- A timeout fault asserts on the edge where dur_cnt would become max+1.
- Single-cycle glitch codes count as change events. They are checked like any other code: a legal glitch is a duration fault, an illegal one is a code fault.

## Test plan
Parameters for all scenarios: DUR_MIN=3, DUR_MAX=5, DUR_MAX_LONG=10.
- Legal loop: drive codes 0,1,2,3,4,5,0 for 4 cycles each, repeated twice -> phase steps 0..5, last_dur=4 at each change, cycle_done pulses twice, cycle_count=2, fault=0.
- Sync ambiguity: release reset with light=001001 for 6 cycles, then 100001 -> phase_valid stays 0 until 100001, then phase=3; no fault.
- Illegal code: from TRACK in phase 1, drive 111000 -> fault=1, fault_code=01, phase_valid=0. Then a legal 0..5 sequence -> relock; fault_code stays 01.
- Skip: phase 0 then 100001 -> fault_code=10, SYNC.
- Duration window: phase 1 held 2 cycles -> fault_code=11.
- Duration timeout: phase 3 held 11 cycles -> fault 11 on the 11th edge. Phase 3 held 10 cycles -> no fault.
- Async reset mid-phase: assert rst between edges during phase 4 -> all outputs return to reset values before the next edge; count restarts from 0.
